// File: rtl/cf_sweep_ctrl_pkg.sv
// Shared types and constants for the function-block sweep controller.
package cf_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    localparam int          NUM_VEC   = 16;
    localparam logic [15:0] CF_GOLDEN = 16'hA7FF;

    typedef logic [3:0] vec_t;
endpackage

// File: rtl/cf_sweep_ctrl_if.sv
// Control and result bundle between the sweep controller and its user.
interface cf_sweep_ctrl_if;
    import cf_pkg::*;

    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    vec_t        vec_out;
    logic        y_mon;
    logic [15:0] table_out;
    logic        pass;
    logic [4:0]  err_count;
    vec_t        first_err;
    logic        first_err_valid;

    modport master (
        output start, abort,
        input  busy, done, vec_out, y_mon, table_out, pass,
               err_count, first_err, first_err_valid
    );

    modport slave (
        input  start, abort,
        output busy, done, vec_out, y_mon, table_out, pass,
               err_count, first_err, first_err_valid
    );
endinterface

// File: rtl/cf_sweep_ctrl_eval.sv
// Four-input combinational function block under test.
module cf_eval (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic y
);
    assign y = ~a | (~b & ~c) | (b & d) | (~b & ~d);
endmodule

// File: rtl/cf_sweep_ctrl.sv
// Walks all 16 input vectors through cf_eval, captures the truth table
// and publishes a comparison against the EXPECTED golden table.
module cf_sweep_ctrl
    import cf_pkg::*;
#(
    parameter logic [15:0] EXPECTED = CF_GOLDEN,
    parameter int          HOLD     = 1
) (
    input  logic            clk,
    input  logic            rst,
    cf_sweep_ctrl_if.slave  bus
);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    sweep_state_t state_r, state_s;
    vec_t         vec_r, vec_s;
    logic [7:0]   hold_r, hold_s;
    logic [15:0]  work_table_r, work_table_s;
    logic [4:0]   work_err_r, work_err_s;
    vec_t         work_fe_r, work_fe_s;
    logic         work_fev_r, work_fev_s;
    logic         y_s;

    logic         busy_r, done_r, pass_r, fev_r;
    logic [15:0]  table_r;
    logic [4:0]   err_r;
    vec_t         fe_r;

    cf_eval u_eval (
        .a (vec_r[3]),
        .b (vec_r[2]),
        .c (vec_r[1]),
        .d (vec_r[0]),
        .y (y_s)
    );

    // Next-state and working-result computation for the sweep sequencer.
    always_comb begin
        state_s      = state_r;
        vec_s        = vec_r;
        hold_s       = hold_r;
        work_table_s = work_table_r;
        work_err_s   = work_err_r;
        work_fe_s    = work_fe_r;
        work_fev_s   = work_fev_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s      = SWEEP;
                    vec_s        = 4'd0;
                    hold_s       = 8'd0;
                    work_table_s = 16'h0000;
                    work_err_s   = 5'd0;
                    work_fe_s    = 4'd0;
                    work_fev_s   = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            SWEEP: begin
                // Abort has priority over the final sample, so nothing is published.
                if (bus.abort) begin
                    state_s = IDLE;
                    vec_s   = 4'd0;
                    hold_s  = 8'd0;
                end else if (hold_r == HOLD_LAST) begin
                    work_table_s[vec_r] = y_s;
                    hold_s              = 8'd0;
                    if (y_s != EXPECTED[vec_r]) begin
                        work_err_s = work_err_r + 5'd1;
                        if (!work_fev_r) begin
                            work_fe_s  = vec_r;
                            work_fev_s = 1'b1;
                        end else begin
                            work_fe_s  = work_fe_r;
                            work_fev_s = work_fev_r;
                        end
                    end else begin
                        work_err_s = work_err_r;
                    end
                    if (vec_r == 4'd15) begin
                        state_s = DONE;
                    end else begin
                        vec_s = vec_r + 4'd1;
                    end
                end else begin
                    hold_s = hold_r + 8'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, working registers and published results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            vec_r        <= 4'd0;
            hold_r       <= 8'd0;
            work_table_r <= 16'h0000;
            work_err_r   <= 5'd0;
            work_fe_r    <= 4'd0;
            work_fev_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            table_r      <= 16'h0000;
            err_r        <= 5'd0;
            fe_r         <= 4'd0;
            fev_r        <= 1'b0;
            pass_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            vec_r        <= vec_s;
            hold_r       <= hold_s;
            work_table_r <= work_table_s;
            work_err_r   <= work_err_s;
            work_fe_r    <= work_fe_s;
            work_fev_r   <= work_fev_s;
            busy_r       <= (state_s == SWEEP);
            done_r       <= (state_s == DONE);
            if (state_s == DONE) begin
                table_r <= work_table_s;
                err_r   <= work_err_s;
                fe_r    <= work_fe_s;
                fev_r   <= work_fev_s;
                pass_r  <= (work_err_s == 5'd0);
            end
        end
    end

    assign bus.busy            = busy_r;
    assign bus.done            = done_r;
    assign bus.vec_out         = vec_r;
    assign bus.y_mon           = y_s;
    assign bus.table_out       = table_r;
    assign bus.err_count       = err_r;
    assign bus.first_err       = fe_r;
    assign bus.first_err_valid = fev_r;
    assign bus.pass            = pass_r;
endmodule

// File: tb/tb_cf_sweep_ctrl.sv
// Scoreboard bench for cf_sweep_ctrl: five instances with different golden
// tables and hold lengths, driven one scenario task at a time.
module tb_cf_sweep_ctrl;
    import cf_pkg::*;

    typedef struct {
        logic [15:0] tbl;
        logic [4:0]  err;
        logic [3:0]  fe;
        logic        fev;
        logic        pass;
    } exp_t;

    localparam logic [4:0][15:0] EXP_TAB = {16'h0000, 16'hA7FF, 16'h27FF, 16'hA7FE, 16'hA7FF};

    logic        clk;
    logic        rst;
    logic [4:0]  start_s;
    logic [4:0]  abort_s;
    wire  [4:0]  busy_a, done_a, ymon_a, fev_a, pass_a;
    wire  [4:0][3:0]  vec_a, fe_a;
    wire  [4:0][15:0] tbl_a;
    wire  [4:0][4:0]  err_a;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : gen_dut
        cf_sweep_ctrl_if sif ();
        assign sif.start  = start_s[g];
        assign sif.abort  = abort_s[g];
        assign busy_a[g]  = sif.busy;
        assign done_a[g]  = sif.done;
        assign ymon_a[g]  = sif.y_mon;
        assign fev_a[g]   = sif.first_err_valid;
        assign pass_a[g]  = sif.pass;
        assign vec_a[g]   = sif.vec_out;
        assign fe_a[g]    = sif.first_err;
        assign tbl_a[g]   = sif.table_out;
        assign err_a[g]   = sif.err_count;

        cf_sweep_ctrl #(.EXPECTED(EXP_TAB[g]), .HOLD((g == 3) ? 3 : 1)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (sif.slave)
        );
    end

    // Reference function written from its zero set: vectors 11, 12, 14.
    function automatic logic ref_y(input logic [3:0] v);
        return !(v[3] && ((v[2] && !v[0]) || (!v[2] && v[1] && v[0])));
    endfunction

    function automatic exp_t model(input int k);
        exp_t        e;
        logic [15:0] ex;
        ex    = EXP_TAB[k];
        e.tbl = 16'h0000; e.err = 5'd0; e.fe = 4'd0; e.fev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic y;
            y = ref_y(4'(i));
            e.tbl[i] = y;
            if (y != ex[i]) begin
                e.err = e.err + 5'd1;
                if (!e.fev) begin e.fe = 4'(i); e.fev = 1'b1; end
            end
        end
        e.pass = (e.err == 5'd0);
        return e;
    endfunction

    task automatic run_sweep(input int k);
        int   hold, n;
        bit   seen;
        exp_t e;
        logic [3:0] ev;
        hold = (k == 3) ? 3 : 1;
        sb_q.push_back(model(k));
        @(negedge clk) start_s[k] = 1'b1;
        @(negedge clk) start_s[k] = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 16 * hold + 4) begin
            @(negedge clk);
            n++;
            if (done_a[k]) begin
                seen = 1'b1;
                n_checks++; if (n != 16 * hold) begin n_fail++; $display("FAIL done_cycle[%0d]: got %0d want %0d", k, n, 16 * hold); end
                n_checks++; if (busy_a[k] !== 1'b0) begin n_fail++; $display("FAIL busy_at_done[%0d]: got %b want 0", k, busy_a[k]); end
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++; $display("FAIL scoreboard_empty[%0d]: got done want no done", k);
                end else begin
                    e = sb_q.pop_front();
                    if (tbl_a[k] !== e.tbl) begin n_fail++; $display("FAIL table_out[%0d]: got %h want %h", k, tbl_a[k], e.tbl); end
                    n_checks++; if (err_a[k] !== e.err) begin n_fail++; $display("FAIL err_count[%0d]: got %0d want %0d", k, err_a[k], e.err); end
                    n_checks++; if (fe_a[k] !== e.fe) begin n_fail++; $display("FAIL first_err[%0d]: got %0d want %0d", k, fe_a[k], e.fe); end
                    n_checks++; if (fev_a[k] !== e.fev) begin n_fail++; $display("FAIL first_err_valid[%0d]: got %b want %b", k, fev_a[k], e.fev); end
                    n_checks++; if (pass_a[k] !== e.pass) begin n_fail++; $display("FAIL pass[%0d]: got %b want %b", k, pass_a[k], e.pass); end
                end
            end else begin
                n_checks++; if (busy_a[k] !== 1'b1) begin n_fail++; $display("FAIL busy[%0d] cycle %0d: got %b want 1", k, n, busy_a[k]); end
                if (n < 16 * hold) begin
                    ev = 4'(n / hold);
                    n_checks++; if (vec_a[k] !== ev) begin n_fail++; $display("FAIL vec_out[%0d] cycle %0d: got %0d want %0d", k, n, vec_a[k], ev); end
                    n_checks++; if (ymon_a[k] !== ref_y(ev)) begin n_fail++; $display("FAIL y_mon[%0d] vec %0d: got %b want %b", k, ev, ymon_a[k], ref_y(ev)); end
                end
            end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL done_timeout[%0d]: got no done want done", k); end
        @(negedge clk);
        n_checks++; if (done_a[k] !== 1'b0) begin n_fail++; $display("FAIL done_width[%0d]: got %b want 0", k, done_a[k]); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_s = 5'd0; abort_s = 5'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (busy_a[k] !== 1'b0 || done_a[k] !== 1'b0 || pass_a[k] !== 1'b0 || fev_a[k] !== 1'b0) begin
                n_fail++; $display("FAIL reset_flags[%0d]: got %b%b%b%b want 0000", k, busy_a[k], done_a[k], pass_a[k], fev_a[k]);
            end
            n_checks++; if (vec_a[k] !== 4'd0 || fe_a[k] !== 4'd0 || err_a[k] !== 5'd0 || tbl_a[k] !== 16'h0000) begin
                n_fail++; $display("FAIL reset_values[%0d]: got %0d %0d %0d %h want 0 0 0 0000", k, vec_a[k], fe_a[k], err_a[k], tbl_a[k]);
            end
        end
        n_checks++; if (ymon_a[0] !== 1'b1) begin n_fail++; $display("FAIL reset_y_mon: got %b want 1", ymon_a[0]); end
    endtask

    task automatic test_golden();
        run_sweep(0);
        n_checks++; if (tbl_a[0] !== 16'hA7FF) begin n_fail++; $display("FAIL golden_table: got %h want a7ff", tbl_a[0]); end
    endtask

    task automatic test_mismatch();
        run_sweep(1);
        n_checks++; if (err_a[1] !== 5'd1 || fe_a[1] !== 4'd0) begin n_fail++; $display("FAIL mismatch_lsb: got err %0d first %0d want 1 0", err_a[1], fe_a[1]); end
        run_sweep(2);
        n_checks++; if (err_a[2] !== 5'd1 || fe_a[2] !== 4'd15) begin n_fail++; $display("FAIL mismatch_msb: got err %0d first %0d want 1 15", err_a[2], fe_a[2]); end
    endtask

    task automatic test_hold();
        run_sweep(3);
    endtask

    task automatic test_abort();
        int dcount;
        @(negedge clk) start_s[0] = 1'b1;
        @(negedge clk) start_s[0] = 1'b0;
        repeat (5) @(negedge clk);
        abort_s[0] = 1'b1;
        @(negedge clk) abort_s[0] = 1'b0;
        n_checks++; if (busy_a[0] !== 1'b0 || vec_a[0] !== 4'd0 || done_a[0] !== 1'b0) begin
            n_fail++; $display("FAIL abort_state: got busy %b vec %0d done %b want 0 0 0", busy_a[0], vec_a[0], done_a[0]);
        end
        n_checks++; if (tbl_a[0] !== 16'hA7FF || err_a[0] !== 5'd0 || pass_a[0] !== 1'b1 || fev_a[0] !== 1'b0) begin
            n_fail++; $display("FAIL abort_published: got %h %0d %b %b want a7ff 0 1 0", tbl_a[0], err_a[0], pass_a[0], fev_a[0]);
        end
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_a[0]) dcount++;
        end
        n_checks++; if (dcount != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", dcount); end
        run_sweep(0);
    endtask

    task automatic test_start_ignore();
        int   dcount;
        exp_t e;
        sb_q.push_back(model(0));
        @(negedge clk) start_s[0] = 1'b1;
        @(negedge clk) start_s[0] = 1'b0;
        dcount = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done_a[0]) begin
                dcount++;
                n_checks++; if (n != 16) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d want 16", n); end
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++; $display("FAIL ignore_extra_done: got done want no done");
                end else begin
                    e = sb_q.pop_front();
                    if (tbl_a[0] !== e.tbl || err_a[0] !== e.err || pass_a[0] !== e.pass) begin
                        n_fail++; $display("FAIL ignore_results: got %h %0d %b want %h %0d %b", tbl_a[0], err_a[0], pass_a[0], e.tbl, e.err, e.pass);
                    end
                end
            end
            start_s[0] = (n == 3 || n == 16) ? 1'b1 : 1'b0;
        end
        n_checks++; if (dcount != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", dcount); end
        n_checks++; if (busy_a[0] !== 1'b0) begin n_fail++; $display("FAIL ignore_idle: got busy %b want 0", busy_a[0]); end
    endtask

    task automatic test_zero();
        run_sweep(4);
        n_checks++; if (err_a[4] !== 5'd13 || fe_a[4] !== 4'd0 || pass_a[4] !== 1'b0) begin
            n_fail++; $display("FAIL zero_table: got err %0d first %0d pass %b want 13 0 0", err_a[4], fe_a[4], pass_a[4]);
        end
    endtask

    task automatic test_rst_mid();
        @(negedge clk) start_s[0] = 1'b1;
        @(negedge clk) start_s[0] = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        n_checks++; if (busy_a[0] !== 1'b0 || done_a[0] !== 1'b0 || pass_a[0] !== 1'b0 || fev_a[0] !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_flags: got %b%b%b%b want 0000", busy_a[0], done_a[0], pass_a[0], fev_a[0]);
        end
        n_checks++; if (vec_a[0] !== 4'd0 || fe_a[0] !== 4'd0 || err_a[0] !== 5'd0 || tbl_a[0] !== 16'h0000) begin
            n_fail++; $display("FAIL rst_mid_values: got %0d %0d %0d %h want 0 0 0 0000", vec_a[0], fe_a[0], err_a[0], tbl_a[0]);
        end
        repeat (20) @(negedge clk);
        n_checks++; if (busy_a[0] !== 1'b0 || tbl_a[0] !== 16'h0000) begin
            n_fail++; $display("FAIL rst_mid_stays_idle: got busy %b table %h want 0 0000", busy_a[0], tbl_a[0]);
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_mismatch();
        test_hold();
        test_abort();
        test_start_ignore();
        test_zero();
        test_rst_mid();
        n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d entries want 0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
